id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the RISC-V core, sitting directly upstream of the ALU. It registers the decoded instruction and applies EX/MEM and MEM/WB operand forwarding. It drives the ALU operands `A` and `B` and the `alu_control` code. It also detects load-use hazards, inserts the required bubble, and back-pressures decode.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REGW`, 5, register index width

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `id_valid` in 1: decode presents an instruction
- `id_ready` out 1: stage accepts the decode instruction this cycle
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in XLEN: decoded values
- `id_rs1`, `id_rs2`, `id_rd` in REGW: register indices
- `id_use_rs1`, `id_use_rs2` in 1: instruction reads rs1 / rs2
- `id_alu_control` in 4: ALU op, team encoding (add=0000 … sltu=1001, lui=1111)
- `id_alu_src_a` in 1: 0 = rs1, 1 = pc
- `id_alu_src_b` in 1: 0 = rs2, 1 = imm
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: control bits
- `stall_in` in 1: downstream freeze (memory busy)
- `flush` in 1: branch/jump redirect, kill the instruction being loaded
- `exm_reg_write` in 1, `exm_rd` in REGW, `exm_result` in XLEN: EX/MEM forward source
- `wb_reg_write` in 1, `wb_rd` in REGW, `wb_result` in XLEN: MEM/WB forward source
- `A`, `B` out XLEN: ALU operands
- `alu_control` out 4: ALU op
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: registered control
- `ex_rd` out REGW: registered destination
- `ex_store_data` out XLEN: forwarded rs2 for stores
- `load_use_stall` out 1: hazard indication (combinational)

## Operation
- Internal registers hold pc, rs1_data, rs2_data, imm, rs1, rs2, rd, use bits, alu_control, src selects, and control bits (together: ex fields).
- Forwarding is applied per operand on the registered index `r`.
  - If `r != 0` and `exm_reg_write` and `exm_rd == r`, the value is `exm_result`.
  - Otherwise, if `r != 0` and `wb_reg_write` and `wb_rd == r`, the value is `wb_result`.
  - Otherwise the value is the stored data.
  - EX/MEM has priority over MEM/WB.
- Operand outputs:
  - `A = src_a ? pc : fwd_rs1`
  - `B = src_b ? imm : fwd_rs2`
  - `ex_store_data = fwd_rs2`
- `load_use_stall` = `ex_valid & ex_mem_read & ex_rd != 0 & id_valid & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))`.
- `id_ready = !stall_in & !load_use_stall`.
- Per-edge update, in priority order:
  1. `reset`: all ex fields become 0. `ex_valid = 0` and `alu_control = 0000`.
  2. `flush`: load a bubble.
  3. `stall_in`: hold every field, except that rs1_data and rs2_data are rewritten with their forwarded values. A value forwarded from MEM/WB is therefore not lost when WB retires during the hold.
  4. `load_use_stall`: load a bubble. Decode holds its instruction.
  5. Otherwise: load the id_* fields, with `ex_valid = id_valid`.
- Bubble: `ex_valid = 0`, all control bits 0, `ex_rd = 0`, `alu_control = 0000`, data fields 0.
- When `ex_valid = 0`, `A` and `B` are don't-care but deterministic (derived from the zeroed fields).
- `flush` together with `load_use_stall`: result is a bubble, and `id_ready` still follows its formula.

## Timing
- Reset values: `A = 0`, `B = 0`, `alu_control = 0000`, `ex_valid = 0`, `ex_rd = 0`, all ex control bits 0, `ex_store_data = 0`.
- `id_ready` and `load_use_stall` are 0 after reset unless the stated formulas apply.
- Latency: an instruction accepted at edge N drives `A`, `B`, `alu_control` from N until the next update. The path from forward inputs to `A`, `B` is combinational.
- A load followed by a dependent instruction costs exactly one bubble cycle. The dependent instruction then receives the load data via the MEM/WB path.
- Reset asserted mid-stall or mid-bubble clears all fields immediately (asynchronously). No partial state survives.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`, `REGW`
  - ALU opcode constants (add, sub, orr, andd, xorr, slt, sll, srl, sra, sltu, lui)
  - packed struct `ex_ctrl_t` {reg_write, mem_read, mem_write, alu_src_a, alu_src_b, alu_control}
- Sub-module `operand_forward`: inputs are index, stored data, and both forward sources; output is the forwarded value. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- **Reset:** assert `reset` mid-run → next sample `ex_valid = 0`, `alu_control = 0000`, `A = B = 0`.
- **EX/MEM forward:** `add x3,x1,x2` with `id_rs1_data = 5`, `id_rs2_data = 7`, `exm_rd = 1`, `exm_result = 100` → `A = 100`, `B = 7`. With `wb_rd = 1`, `wb_result = 9` also driven → `A` is still 100.
- **Load-use:** `lw x5` in EX, then `add x6,x5,x0` at decode → `load_use_stall = 1` and `id_ready = 0` for one cycle. Next edge gives `ex_valid = 0`. The following edge accepts the add, and `wb_rd = 5`, `wb_result = 0xDEAD` gives `A = 0xDEAD`.
- **Stall refresh:** held instruction with rs2 forwarded from WB value 42, `stall_in = 1` for 3 cycles while WB changes to `rd = 0` → `B` stays 42 and `ex_store_data = 42`.
- **Flush priority:** `flush = 1` and `stall_in = 1` with a valid decode instruction → next edge `ex_valid = 0`, `ex_reg_write = 0`.
- **Immediates/x0:** LUI with `id_imm = 0x12345000` and `src_b = 1` → `B = 0x12345000`, `alu_control = 1111`. With `rs1 = 0` and `exm_rd = 0`, `exm_result = 77` → `A` is not forwarded.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, ALU op codes
// and the control bundle carried from decode into EX.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_ORR  = 4'b0010;
    localparam logic [3:0] ALU_ANDD = 4'b0011;
    localparam logic [3:0] ALU_XORR = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [3:0] alu_control;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_NOP = '0;

    function automatic ex_ctrl_t pack_ctrl(
        input logic       reg_write,
        input logic       mem_read,
        input logic       mem_write,
        input logic       alu_src_a,
        input logic       alu_src_b,
        input logic [3:0] alu_control
    );
        ex_ctrl_t c;
        c.reg_write   = reg_write;
        c.mem_read    = mem_read;
        c.mem_write   = mem_write;
        c.alu_src_a   = alu_src_a;
        c.alu_src_b   = alu_src_b;
        c.alu_control = alu_control;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// Per-operand bypass: picks the youngest in-flight
// write to the register index, EX/MEM before MEM/WB.
module operand_forward #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] idx,
    input  logic [XLEN-1:0] data,
    input  logic            exm_reg_write,
    input  logic [REGW-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_reg_write,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] fwd
);

    logic nz;
    logic hit_exm;
    logic hit_wb;

    assign nz      = (idx != '0);
    assign hit_exm = nz && exm_reg_write && (exm_rd == idx);
    assign hit_wb  = nz && wb_reg_write && (wb_rd == idx);

    // x0 is never bypassed; EX/MEM is younger so it wins
    always_comb begin
        fwd = data;
        if (hit_exm) begin
            fwd = exm_result;
        end else if (hit_wb) begin
            fwd = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding,
// load-use bubble insertion and decode back-pressure.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [3:0]      id_alu_control,
    input  logic            id_alu_src_a,
    input  logic            id_alu_src_b,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            stall_in,
    input  logic            flush,
    input  logic            exm_reg_write,
    input  logic [REGW-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            wb_reg_write,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      alu_control,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [REGW-1:0] ex_rd,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_stall
);

    import riscv_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [REGW-1:0] rs1_q;
    logic [REGW-1:0] rs2_q;
    logic [REGW-1:0] rd_q;
    logic            valid_q;
    ex_ctrl_t        ctrl_q;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            rs1_dep;
    logic            rs2_dep;
    logic            ex_is_load;
    logic            bubble;

    operand_forward #(
        .XLEN(XLEN),
        .REGW(REGW)
    ) u_fwd_rs1 (
        .idx          (rs1_q),
        .data         (rs1_data_q),
        .exm_reg_write(exm_reg_write),
        .exm_rd       (exm_rd),
        .exm_result   (exm_result),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .fwd          (fwd_rs1)
    );

    operand_forward #(
        .XLEN(XLEN),
        .REGW(REGW)
    ) u_fwd_rs2 (
        .idx          (rs2_q),
        .data         (rs2_data_q),
        .exm_reg_write(exm_reg_write),
        .exm_rd       (exm_rd),
        .exm_result   (exm_result),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .fwd          (fwd_rs2)
    );

    // A load in EX cannot feed decode until it reaches WB
    assign ex_is_load = valid_q && ctrl_q.mem_read && (rd_q != '0);
    assign rs1_dep    = id_use_rs1 && (id_rs1 == rd_q);
    assign rs2_dep    = id_use_rs2 && (id_rs2 == rd_q);

    assign load_use_stall = ex_is_load && id_valid && (rs1_dep || rs2_dep);
    assign id_ready       = !stall_in && !load_use_stall;

    // Flush always kills; the hazard bubble only when not frozen
    assign bubble = flush || (!stall_in && load_use_stall);

    // Pipeline register update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            ctrl_q     <= EX_CTRL_NOP;
        end else if (bubble) begin
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            ctrl_q     <= EX_CTRL_NOP;
        end else if (stall_in) begin
            // capture bypassed values so WB retiring cannot lose them
            rs1_data_q <= fwd_rs1;
            rs2_data_q <= fwd_rs2;
        end else begin
            pc_q       <= id_pc;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rd_q       <= id_rd;
            valid_q    <= id_valid;
            ctrl_q     <= pack_ctrl(id_reg_write, id_mem_read,
                                    id_mem_write, id_alu_src_a,
                                    id_alu_src_b, id_alu_control);
        end
    end

    assign A             = ctrl_q.alu_src_a ? pc_q : fwd_rs1;
    assign B             = ctrl_q.alu_src_b ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

    assign alu_control  = ctrl_q.alu_control;
    assign ex_valid     = valid_q;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_rd        = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios
// plus randomized traffic against an instruction-level model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [3:0]  id_alu_control;
    logic        id_alu_src_a, id_alu_src_b;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        stall_in, flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [31:0] A, B;
    logic [3:0]  alu_control;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_store_data;
    logic        load_use_stall;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_alu_control(id_alu_control),
        .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write),
        .stall_in(stall_in), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
        .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_result(wb_result),
        .A(A), .B(B), .alu_control(alu_control),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .load_use_stall(load_use_stall)
    );

    // Reference view of the instruction sitting in EX
    typedef struct {
        logic        valid;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, sa, sb;
        logic [3:0]  alu;
    } instr_t;

    instr_t m;

    function automatic instr_t empty_instr();
        instr_t e;
        e.valid = 0; e.pc = 0; e.r1d = 0; e.r2d = 0; e.imm = 0;
        e.rs1 = 0; e.rs2 = 0; e.rd = 0;
        e.rw = 0; e.mr = 0; e.mw = 0; e.sa = 0; e.sb = 0; e.alu = 0;
        return e;
    endfunction

    // Architectural value of register r as seen by EX right now
    function automatic logic [31:0] reg_value(input logic [4:0] r,
                                              input logic [31:0] stored);
        if (r == 0) return stored;
        if (exm_reg_write && exm_rd == r) return exm_result;
        if (wb_reg_write && wb_rd == r) return wb_result;
        return stored;
    endfunction

    task automatic drive_idle();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_alu_control = 0;
        id_alu_src_a = 0; id_alu_src_b = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        stall_in = 0; flush = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        tick();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ex_valid); end
        checks++; if (alu_control !== 4'b0000) begin failures++; $display("FAIL rst_alu got=%b exp=0000", alu_control); end
        checks++; if (A !== 32'h0 || B !== 32'h0) begin failures++; $display("FAIL rst_ab got=%h/%h exp=0/0", A, B); end
        checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000 || ex_rd !== 5'd0) begin failures++; $display("FAIL rst_ctrl got=%b rd=%0d exp=000 rd=0", {ex_reg_write, ex_mem_read, ex_mem_write}, ex_rd); end
        checks++; if (ex_store_data !== 32'h0) begin failures++; $display("FAIL rst_store got=%h exp=0", ex_store_data); end
        checks++; if (load_use_stall !== 1'b0 || id_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=lus%b rdy%b exp=lus0 rdy1", load_use_stall, id_ready); end
        reset = 0;
        id_valid = 1; id_pc = 32'h100; id_rs1_data = 32'h11;
        id_rs2_data = 32'h22; id_rd = 7; id_alu_control = 4'b0001;
        id_reg_write = 1;
        tick();
        checks++; if (ex_valid !== 1'b1 || A !== 32'h11) begin failures++; $display("FAIL rst_load got=v%b A=%h exp=v1 A=11", ex_valid, A); end
        stall_in = 1;
        tick();
        #2 reset = 1;
        #1;
        checks++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_reg_write !== 1'b0) begin failures++; $display("FAIL rst_async got=v%b rd=%0d rw=%b exp=v0 rd0 rw0", ex_valid, ex_rd, ex_reg_write); end
        checks++; if (A !== 32'h0 || B !== 32'h0 || alu_control !== 4'b0) begin failures++; $display("FAIL rst_async_ab got=%h/%h/%b exp=0/0/0000", A, B, alu_control); end
        #2 reset = 0;
        drive_idle();
    endtask

    task automatic test_exm_forward();
        drive_idle();
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 3;
        id_use_rs1 = 1; id_use_rs2 = 1;
        id_rs1_data = 5; id_rs2_data = 7; id_reg_write = 1;
        exm_reg_write = 1; exm_rd = 1; exm_result = 100;
        tick();
        id_valid = 0;
        checks++; if (A !== 32'd100 || B !== 32'd7) begin failures++; $display("FAIL exm_fwd got=%0d/%0d exp=100/7", A, B); end
        checks++; if (ex_rd !== 5'd3 || alu_control !== 4'b0000) begin failures++; $display("FAIL exm_rd got=%0d/%b exp=3/0000", ex_rd, alu_control); end
        wb_reg_write = 1; wb_rd = 1; wb_result = 9;
        #1;
        checks++; if (A !== 32'd100) begin failures++; $display("FAIL exm_prio got=%0d exp=100", A); end
        exm_reg_write = 0;
        #1;
        checks++; if (A !== 32'd9) begin failures++; $display("FAIL wb_fwd got=%0d exp=9", A); end
        drive_idle();
    endtask

    task automatic test_load_use();
        drive_idle();
        id_valid = 1; id_rd = 5; id_mem_read = 1; id_reg_write = 1;
        id_use_rs1 = 1; id_rs1 = 0; id_imm = 4; id_alu_src_b = 1;
        tick();
        id_mem_read = 0; id_rd = 6; id_rs1 = 5; id_rs2 = 0;
        id_use_rs1 = 1; id_use_rs2 = 1; id_alu_src_b = 0;
        id_rs1_data = 32'h1234; id_imm = 0;
        #1;
        checks++; if (load_use_stall !== 1'b1 || id_ready !== 1'b0) begin failures++; $display("FAIL lu_detect got=lus%b rdy%b exp=lus1 rdy0", load_use_stall, id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || load_use_stall !== 1'b0 || id_ready !== 1'b1) begin failures++; $display("FAIL lu_bubble got=v%b lus%b rdy%b exp=v0 lus0 rdy1", ex_valid, load_use_stall, id_ready); end
        wb_reg_write = 1; wb_rd = 5; wb_result = 32'hDEAD;
        tick();
        id_valid = 0;
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || A !== 32'hDEAD) begin failures++; $display("FAIL lu_accept got=v%b rd=%0d A=%h exp=v1 rd6 A=dead", ex_valid, ex_rd, A); end
        drive_idle();
    endtask

    task automatic test_stall_refresh();
        drive_idle();
        id_valid = 1; id_rs2 = 4; id_use_rs2 = 1; id_rs2_data = 1;
        id_rs1_data = 32'h40; id_imm = 8; id_mem_write = 1;
        tick();
        id_valid = 0;
        wb_reg_write = 1; wb_rd = 4; wb_result = 42; stall_in = 1;
        #1;
        checks++; if (B !== 32'd42) begin failures++; $display("FAIL stall_pre got=%0d exp=42", B); end
        tick();
        wb_rd = 0; wb_result = 99;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (B !== 32'd42 || ex_store_data !== 32'd42 || ex_valid !== 1'b1) begin failures++; $display("FAIL stall_hold%0d got=B%0d st%0d v%b exp=42/42/1", i, B, ex_store_data, ex_valid); end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_flush_priority();
        drive_idle();
        id_valid = 1; id_rd = 8; id_reg_write = 1;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin failures++; $display("FAIL flush_pre got=v%b rw%b exp=v1 rw1", ex_valid, ex_reg_write); end
        id_rd = 9; flush = 1; stall_in = 1;
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0) begin failures++; $display("FAIL flush_prio got=v%b rw%b rd%0d exp=v0 rw0 rd0", ex_valid, ex_reg_write, ex_rd); end
        drive_idle();
    endtask

    task automatic test_lui_x0();
        drive_idle();
        id_valid = 1; id_imm = 32'h12345000; id_alu_src_b = 1;
        id_alu_control = 4'b1111; id_rd = 10; id_reg_write = 1;
        exm_reg_write = 1; exm_rd = 0; exm_result = 77;
        wb_reg_write = 1; wb_rd = 0; wb_result = 55;
        tick();
        id_valid = 0;
        checks++; if (B !== 32'h12345000 || alu_control !== 4'b1111) begin failures++; $display("FAIL lui_b got=%h/%b exp=12345000/1111", B, alu_control); end
        checks++; if (A !== 32'h0) begin failures++; $display("FAIL x0_nofwd got=%h exp=0", A); end
        drive_idle();
    endtask

    task automatic test_random();
        instr_t nxt;
        logic [31:0] ea, eb, es;
        logic elus, erdy;
        drive_idle();
        reset = 1;
        tick();
        reset = 0;
        m = empty_instr();
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 9) < 7);
            id_pc = $urandom; id_rs1_data = $urandom;
            id_rs2_data = $urandom; id_imm = $urandom;
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
            id_alu_control = 4'($urandom);
            id_alu_src_a = 1'($urandom); id_alu_src_b = 1'($urandom);
            id_reg_write = 1'($urandom);
            id_mem_read = ($urandom_range(0, 9) < 4);
            id_mem_write = 1'($urandom);
            stall_in = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 11) == 0);
            exm_reg_write = 1'($urandom);
            exm_rd = 5'($urandom_range(0, 3));
            exm_result = $urandom;
            wb_reg_write = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3));
            wb_result = $urandom;
            #1;
            ea = m.sa ? m.pc : reg_value(m.rs1, m.r1d);
            es = reg_value(m.rs2, m.r2d);
            eb = m.sb ? m.imm : es;
            elus = m.valid && m.mr && m.rd != 0 && id_valid &&
                   ((id_use_rs1 && id_rs1 == m.rd) ||
                    (id_use_rs2 && id_rs2 == m.rd));
            erdy = !stall_in && !elus;
            checks++; if (A !== ea || B !== eb || ex_store_data !== es) begin failures++; $display("FAIL rnd_ops[%0d] got=%h/%h/%h exp=%h/%h/%h", i, A, B, ex_store_data, ea, eb, es); end
            checks++; if (load_use_stall !== elus || id_ready !== erdy) begin failures++; $display("FAIL rnd_hz[%0d] got=lus%b rdy%b exp=lus%b rdy%b", i, load_use_stall, id_ready, elus, erdy); end
            if (flush) begin
                nxt = empty_instr();
            end else if (stall_in) begin
                nxt = m;
                nxt.r1d = reg_value(m.rs1, m.r1d);
                nxt.r2d = es;
            end else if (elus) begin
                nxt = empty_instr();
            end else begin
                nxt.valid = id_valid; nxt.pc = id_pc;
                nxt.r1d = id_rs1_data; nxt.r2d = id_rs2_data;
                nxt.imm = id_imm; nxt.rs1 = id_rs1; nxt.rs2 = id_rs2;
                nxt.rd = id_rd; nxt.rw = id_reg_write;
                nxt.mr = id_mem_read; nxt.mw = id_mem_write;
                nxt.sa = id_alu_src_a; nxt.sb = id_alu_src_b;
                nxt.alu = id_alu_control;
            end
            tick();
            m = nxt;
            checks++; if (ex_valid !== m.valid || ex_rd !== m.rd || alu_control !== m.alu || {ex_reg_write, ex_mem_read, ex_mem_write} !== {m.rw, m.mr, m.mw}) begin failures++; $display("FAIL rnd_reg[%0d] got=v%b rd%0d alu%b c%b exp=v%b rd%0d alu%b c%b", i, ex_valid, ex_rd, alu_control, {ex_reg_write, ex_mem_read, ex_mem_write}, m.valid, m.rd, m.alu, {m.rw, m.mr, m.mw}); end
        end
        drive_idle();
    endtask

    initial begin
        reset = 1;
        drive_idle();
        test_reset();
        test_exm_forward();
        test_load_use();
        test_stall_refresh();
        test_flush_priority();
        test_lui_x0();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
